// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared types and constants for the elastic pipeline stages
package cpu_pipe_pkg;

    localparam int          DEFAULT_DATA_W = 32;
    localparam int          DEFAULT_PC_W   = 32;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    // Entry count of a 2-deep skid stage; also the occupancy encoding
    typedef enum logic [1:0] {
        STAGE_EMPTY = 2'd0,
        STAGE_ONE   = 2'd1,
        STAGE_TWO   = 2'd2
    } stage_state_e;

endpackage

// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - elastic IF/ID register with 2-entry skid buffer
module if_id_skid_stage
    import cpu_pipe_pkg::*;
#(
    parameter int                DATA_W = DEFAULT_DATA_W,
    parameter int                PC_W   = DEFAULT_PC_W,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        occupancy
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        occupancy_q, occupancy_d;

    logic in_fire;
    logic out_fire;

    // Handshakes use only registered ready/valid, so no input reaches an output combinationally
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next-state and payload movement; flush wins over any handshake
    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (!flush_n) begin
            state_d      = STAGE_EMPTY;
            main_instr_d = BUBBLE;
            main_pc_d    = '0;
            skid_instr_d = BUBBLE;
            skid_pc_d    = '0;
        end else begin
            case (state_q)
                STAGE_EMPTY: begin
                    if (in_fire) begin
                        state_d      = STAGE_ONE;
                        main_instr_d = in_instr;
                        main_pc_d    = in_pc;
                    end
                end
                STAGE_ONE: begin
                    if (in_fire && out_fire) begin
                        main_instr_d = in_instr;
                        main_pc_d    = in_pc;
                    end else if (in_fire) begin
                        state_d      = STAGE_TWO;
                        skid_instr_d = in_instr;
                        skid_pc_d    = in_pc;
                    end else if (out_fire) begin
                        state_d      = STAGE_EMPTY;
                        main_instr_d = BUBBLE;
                        main_pc_d    = '0;
                    end
                end
                STAGE_TWO: begin
                    // in_ready is low here, so only the drain side can move
                    if (out_fire) begin
                        state_d      = STAGE_ONE;
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                        skid_instr_d = BUBBLE;
                        skid_pc_d    = '0;
                    end
                end
                default: begin
                    state_d      = STAGE_EMPTY;
                    main_instr_d = BUBBLE;
                    main_pc_d    = '0;
                    skid_instr_d = BUBBLE;
                    skid_pc_d    = '0;
                end
            endcase
        end
    end

    // Status flags precomputed from the next state so they leave the stage as plain flops
    always_comb begin
        in_ready_d  = (state_d != STAGE_TWO);
        out_valid_d = (state_d != STAGE_EMPTY);
        occupancy_d = 2'd0;
        case (state_d)
            STAGE_ONE: occupancy_d = 2'd1;
            STAGE_TWO: occupancy_d = 2'd2;
            default:   occupancy_d = 2'd0;
        endcase
    end

    // State and payload registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= STAGE_EMPTY;
            main_instr_q <= BUBBLE;
            main_pc_q    <= '0;
            skid_instr_q <= BUBBLE;
            skid_pc_q    <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            occupancy_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            occupancy_q  <= occupancy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_instr = main_instr_q;
    assign out_pc    = main_pc_q;
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb/tb_if_id_skid_stage.sv - randomized and directed bench for if_id_skid_stage
module tb_if_id_skid_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [1:0]  occupancy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t mq[$];

    if_id_skid_stage #(
        .DATA_W (32),
        .PC_W   (32),
        .BUBBLE (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush_n   (flush_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two entries
    function automatic logic m_in_ready();
        return mq.size() < 2;
    endfunction

    always @(negedge reset) mq.delete();

    always @(posedge clk) begin
        if (reset) begin
            logic in_f, out_f;
            in_f  = in_valid && m_in_ready();
            out_f = out_ready && (mq.size() > 0);
            if (!flush_n) begin
                mq.delete();
            end else begin
                if (out_f) void'(mq.pop_front());
                if (in_f) mq.push_back('{instr: in_instr, pc: in_pc});
            end
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(m_in_ready()));
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        chk("out_instr", 64'(out_instr), (mq.size() > 0) ? 64'(mq[0].instr) : 64'd0);
        chk("out_pc", 64'(out_pc), (mq.size() > 0) ? 64'(mq[0].pc) : 64'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl_n);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = 32'h2008_0000 | (pc >> 2);
        out_ready = ordy;
        flush_n   = fl_n;
    endtask

    initial begin
        logic [31:0] rpc;
        tick();
        tick();
        reset = 1'b1;

        // Reset, then idle
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);

        // Full-rate stream
        drive(1, 32'h100, 1, 1);
        in_instr = 32'h2008_0005;
        tick();
        chk("stream0_pc", 64'(out_pc), 64'h100);
        chk("stream0_instr", 64'(out_instr), 64'h2008_0005);
        drive(1, 32'h104, 1, 1);
        tick();
        chk("stream1_pc", 64'(out_pc), 64'h104);
        chk("stream1_valid", 64'(out_valid), 64'd1);
        drive(1, 32'h108, 1, 1);
        tick();
        chk("stream2_pc", 64'(out_pc), 64'h108);
        drive(0, 32'h0, 1, 1);
        tick();
        chk("stream_drain", 64'(out_valid), 64'd0);

        // Backpressure for three cycles
        drive(1, 32'h100, 0, 1);
        tick();
        chk("bp_occ1", 64'(occupancy), 64'd1);
        drive(1, 32'h104, 0, 1);
        tick();
        chk("bp_occ2", 64'(occupancy), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        drive(1, 32'h108, 0, 1);
        tick();
        chk("bp_hold_pc", 64'(out_pc), 64'h100);
        drive(1, 32'h108, 1, 1);
        tick();
        chk("bp_rel_pc1", 64'(out_pc), 64'h104);
        chk("bp_rel_ready", 64'(in_ready), 64'd1);
        tick();
        chk("bp_rel_pc2", 64'(out_pc), 64'h108);
        drive(0, 32'h0, 1, 1);
        tick();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Flush while full, with an instruction offered
        drive(1, 32'h300, 0, 1);
        tick();
        drive(1, 32'h304, 0, 1);
        tick();
        chk("fl_occ2", 64'(occupancy), 64'd2);
        drive(1, 32'h308, 0, 0);
        tick();
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_occ", 64'(occupancy), 64'd0);
        chk("fl_instr", 64'(out_instr), 64'd0);
        drive(0, 32'h0, 1, 1);
        tick();
        chk("fl_after", 64'(out_valid), 64'd0);

        // Flush with one entry and an accepted transfer in the same cycle
        drive(1, 32'h400, 0, 1);
        tick();
        drive(1, 32'h404, 0, 0);
        tick();
        chk("fl1_occ", 64'(occupancy), 64'd0);
        drive(0, 32'h0, 1, 1);
        tick();
        chk("fl1_after", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-cycle in state ONE
        drive(1, 32'h500, 0, 1);
        tick();
        drive(0, 32'h0, 0, 1);
        chk("ar_pre_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_occ", 64'(occupancy), 64'd0);
        chk("ar_pc", 64'(out_pc), 64'd0);
        tick();
        #2;
        reset = 1'b1;
        tick();
        drive(1, 32'h200, 1, 1);
        tick();
        chk("ar_new_pc", 64'(out_pc), 64'h200);
        chk("ar_new_valid", 64'(out_valid), 64'd1);
        drive(0, 32'h0, 1, 1);
        tick();

        // Random traffic with occasional flush
        rpc = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            logic iv;
            iv = ($urandom_range(0, 3) != 0);
            drive(iv, rpc, ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) != 0));
            in_instr = $urandom;
            if (iv && m_in_ready()) rpc = rpc + 32'd4;
            if ((i % 64) == 5) begin
                // in_ready must not follow a mid-cycle change of out_ready
                out_ready = ~out_ready;
                #1;
                chk("ready_no_comb", 64'(in_ready), 64'(m_in_ready()));
                out_ready = ~out_ready;
            end
            tick();
        end

        drive(0, 32'h0, 1, 1);
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
